// File: rtl/i2c_report_pkg.sv
// Shared types for the I2C report arbiter.
// Report record, FSM state and the round-robin pointer step.
package i2c_report_pkg;

   localparam int REPORT_W  = 8;
   localparam int SRC_IDX_W = 2;

   typedef enum logic [1:0] {
      OPEN,
      FROZEN,
      COMMIT
   } state_t;

   typedef struct packed {
      logic [REPORT_W-1:0]  x;
      logic [REPORT_W-1:0]  y;
      logic [REPORT_W-1:0]  status;
      logic [SRC_IDX_W-1:0] src;
   } report_t;

   function automatic logic [SRC_IDX_W-1:0] rr_next(
      input logic [SRC_IDX_W-1:0] idx,
      input int                   n
   );
      return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
   endfunction

endpackage

// File: rtl/i2c_report_arbiter_if.sv
// Producer-side bundle: per-source valid/ready with packed
// x/y/status bytes, source i occupying bits [8i+7:8i].
interface i2c_report_arbiter_if #(
   parameter int NUM_SRC = 2
);
   import i2c_report_pkg::*;

   logic [NUM_SRC-1:0]          valid;
   logic [NUM_SRC-1:0]          ready;
   logic [REPORT_W*NUM_SRC-1:0] x;
   logic [REPORT_W*NUM_SRC-1:0] y;
   logic [REPORT_W*NUM_SRC-1:0] status;

   modport master (
      output valid, x, y, status,
      input  ready
   );

   modport slave (
      input  valid, x, y, status,
      output ready
   );

endinterface

// File: rtl/i2c_bus_monitor.sv
// Synchronises raw SCL/SDA taps and emits 1-cycle START,
// STOP and SCL-edge strobes.
module i2c_bus_monitor (
   input  logic clk,
   input  logic rst,
   input  logic scl,
   input  logic sda_in,
   output logic start,
   output logic stop,
   output logic scl_edge
);

   logic [1:0] scl_sync;
   logic [1:0] sda_sync;
   logic       scl_hist;
   logic       sda_hist;

   // Flops reset to the idle-bus level so release makes no strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_hist <= 1'b1;
         sda_hist <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], scl};
         sda_sync <= {sda_sync[0], sda_in};
         scl_hist <= scl_sync[1];
         sda_hist <= sda_sync[1];
      end
   end

   assign start    = scl_sync[1] & scl_hist
                   & sda_hist & ~sda_sync[1];
   assign stop     = scl_sync[1] & scl_hist
                   & ~sda_hist & sda_sync[1];
   assign scl_edge = scl_sync[1] ^ scl_hist;

endmodule

// File: rtl/i2c_report_arbiter.sv
// Round-robin report owner for the read-only I2C slave;
// freezes the report from START to STOP and parks late updates.
module i2c_report_arbiter
   import i2c_report_pkg::*;
#(
   parameter int NUM_SRC      = 2,
   parameter int IDLE_TIMEOUT = 50000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 scl,
   input  logic                 sda_in,
   i2c_report_arbiter_if.slave  req,
   output logic [REPORT_W-1:0]  x_pos,
   output logic [REPORT_W-1:0]  y_pos,
   output logic [REPORT_W-1:0]  status,
   output logic [SRC_IDX_W-1:0] report_src,
   output logic [7:0]           report_seq,
   output logic                 bus_busy,
   output logic [7:0]           overrun_cnt,
   output logic                 timeout_pulse
);

   localparam int TW = $clog2(IDLE_TIMEOUT);

   state_t               state;
   logic [SRC_IDX_W-1:0] rr_ptr;
   logic [SRC_IDX_W-1:0] grant;
   logic                 any_valid;
   logic                 accept;
   report_t              cand;
   report_t              pend;
   logic                 pend_full;
   logic [TW-1:0]        timer;
   logic                 idle_hit;
   logic                 start;
   logic                 stop;
   logic                 scl_edge;

   i2c_bus_monitor u_mon (
      .clk      (clk),
      .rst      (rst),
      .scl      (scl),
      .sda_in   (sda_in),
      .start    (start),
      .stop     (stop),
      .scl_edge (scl_edge)
   );

   // Descending scan: the last hit is the closest to rr_ptr
   always_comb begin
      grant     = rr_ptr;
      any_valid = 1'b0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (req.valid[i] &&
                i == (int'(rr_ptr) + k) % NUM_SRC) begin
               grant     = SRC_IDX_W'(i);
               any_valid = 1'b1;
            end
         end
      end
   end

   always_comb begin
      cand      = '0;
      req.ready = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant == SRC_IDX_W'(i)) begin
            cand.x      = req.x[REPORT_W*i +: REPORT_W];
            cand.y      = req.y[REPORT_W*i +: REPORT_W];
            cand.status = req.status[REPORT_W*i +: REPORT_W];
            cand.src    = SRC_IDX_W'(i);
            req.ready[i] = any_valid && (state != COMMIT);
         end
      end
   end

   assign accept   = any_valid && (state != COMMIT);
   assign idle_hit = (timer == TW'(IDLE_TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= OPEN;
         rr_ptr        <= '0;
         pend          <= '0;
         pend_full     <= 1'b0;
         timer         <= '0;
         x_pos         <= '0;
         y_pos         <= '0;
         status        <= '0;
         report_src    <= '0;
         report_seq    <= '0;
         bus_busy      <= 1'b0;
         overrun_cnt   <= '0;
         timeout_pulse <= 1'b0;
      end else begin
         timeout_pulse <= 1'b0;
         if (accept)
            rr_ptr <= rr_next(grant, NUM_SRC);
         unique case (state)
            OPEN: begin
               timer <= '0;
               if (accept) begin
                  x_pos      <= cand.x;
                  y_pos      <= cand.y;
                  status     <= cand.status;
                  report_src <= cand.src;
                  report_seq <= report_seq + 8'd1;
               end
               if (start) begin
                  state    <= FROZEN;
                  bus_busy <= 1'b1;
               end
            end
            FROZEN: begin
               if (accept) begin
                  pend      <= cand;
                  pend_full <= 1'b1;
                  if (pend_full && overrun_cnt != 8'hFF)
                     overrun_cnt <= overrun_cnt + 8'd1;
               end
               if (scl_edge || start)
                  timer <= '0;
               else
                  timer <= timer + TW'(1);
               if (stop) begin
                  state    <= COMMIT;
                  bus_busy <= 1'b0;
               end else if (idle_hit) begin
                  state         <= COMMIT;
                  bus_busy      <= 1'b0;
                  timeout_pulse <= 1'b1;
               end
            end
            COMMIT: begin
               timer <= '0;
               if (pend_full) begin
                  x_pos      <= pend.x;
                  y_pos      <= pend.y;
                  status     <= pend.status;
                  report_src <= pend.src;
                  report_seq <= report_seq + 8'd1;
                  pend_full  <= 1'b0;
               end
               if (start) begin
                  state    <= FROZEN;
                  bus_busy <= 1'b1;
               end else begin
                  state <= OPEN;
               end
            end
            default: state <= OPEN;
         endcase
      end
   end

endmodule
